// File: rtl/grant_bus_ctrl.sv
// rtl/grant_bus_ctrl.sv - grant-driven single-burst owner of a shared target bus
module grant_bus_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gnt_0,
  input  logic              gnt_1,
  input  logic [DATA_W-1:0] data_0,
  input  logic              vld_0,
  output logic              rdy_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic              vld_1,
  output logic              rdy_1,
  output logic [DATA_W-1:0] out_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              done_0,
  output logic              done_1,
  output logic              abort_0,
  output logic              abort_1,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [7:0] LAST_IDLE = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       done_0_q, done_0_d;
  logic       done_1_q, done_1_d;
  logic       abort_0_q, abort_0_d;
  logic       abort_1_q, abort_1_d;
  logic       beat_acc;
  logic       owner_gnt;

  // Forwarding path: steer the owner's stream to the target, everything idle otherwise
  always_comb begin
    out_data = '0;
    out_vld  = 1'b0;
    rdy_0    = 1'b0;
    rdy_1    = 1'b0;
    case (state_q)
      OWN0: begin
        out_data = data_0;
        out_vld  = vld_0;
        rdy_0    = out_rdy & vld_0;
      end
      OWN1: begin
        out_data = data_1;
        out_vld  = vld_1;
        rdy_1    = out_rdy & vld_1;
      end
      default: ;
    endcase
    beat_acc  = out_vld & out_rdy;
    owner_gnt = (state_q == OWN0) ? gnt_0 : gnt_1;
  end

  // Next-state and counter logic; last beat outranks grant drop, which outranks timeout
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    done_0_d   = 1'b0;
    done_1_d   = 1'b0;
    abort_0_d  = 1'b0;
    abort_1_d  = 1'b0;
    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        idle_cnt_d = '0;
        if (gnt_0) begin
          state_d = OWN0;
        end else if (gnt_1) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (beat_acc && beat_cnt_q == LAST_BEAT) begin
          state_d  = FIN;
          done_0_d = (state_q == OWN0);
          done_1_d = (state_q == OWN1);
        end else if (!owner_gnt ||
                     (!beat_acc && idle_cnt_q == LAST_IDLE)) begin
          state_d   = FIN;
          abort_0_d = (state_q == OWN0);
          abort_1_d = (state_q == OWN1);
        end else if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      FIN: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
        idle_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and completion pulses; reset drops any burst without a pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      done_0_q   <= 1'b0;
      done_1_q   <= 1'b0;
      abort_0_q  <= 1'b0;
      abort_1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      done_0_q   <= done_0_d;
      done_1_q   <= done_1_d;
      abort_0_q  <= abort_0_d;
      abort_1_q  <= abort_1_d;
    end
  end

  assign done_0  = done_0_q;
  assign done_1  = done_1_q;
  assign abort_0 = abort_0_q;
  assign abort_1 = abort_1_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_grant_bus_ctrl.sv
// tb/tb_grant_bus_ctrl.sv - directed self-checking bench for grant_bus_ctrl
module tb_grant_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       gnt_0, gnt_1;
  logic [7:0] data_0, data_1;
  logic       vld_0, vld_1;
  logic       rdy_0, rdy_1;
  logic [7:0] out_data;
  logic       out_vld;
  logic       out_rdy;
  logic       done_0, done_1, abort_0, abort_1;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int beats;

  grant_bus_ctrl #(.DATA_W(8), .BURST_LEN(4), .TIMEOUT(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .gnt_0    (gnt_0),
    .gnt_1    (gnt_1),
    .data_0   (data_0),
    .vld_0    (vld_0),
    .rdy_0    (rdy_0),
    .data_1   (data_1),
    .vld_1    (vld_1),
    .rdy_1    (rdy_1),
    .out_data (out_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .done_0   (done_0),
    .done_1   (done_1),
    .abort_0  (abort_0),
    .abort_1  (abort_1),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pulses(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, done_0, done_1, abort_0, abort_1}, {28'd0, exp});
  endtask

  initial begin
    rst = 1'b1; gnt_0 = 0; gnt_1 = 0; data_0 = 0; data_1 = 0;
    vld_0 = 0; vld_1 = 0; out_rdy = 0;

    // 1. reset state and basic burst
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_rdy", {rdy_0, rdy_1}, 0);
    chk_pulses("rst_pulses", 4'b0000);
    gnt_0 = 1; vld_0 = 1; out_rdy = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      data_0 = 8'hA0 + 8'(i);
      #1;
      chk("t1_data", out_data, 8'hA0 + i);
      chk("t1_vld", out_vld, 1);
      chk("t1_rdy", {rdy_0, rdy_1}, 2'b10);
      chk("t1_busy", busy, 1);
      chk_pulses("t1_nopulse", 4'b0000);
      tick();
    end
    gnt_0 = 0; vld_0 = 0;
    #1;
    chk_pulses("t1_done", 4'b1000);
    chk("t1_fin_vld", out_vld, 0);
    chk("t1_fin_busy", busy, 1);
    tick();
    chk("t1_idle_busy", busy, 0);
    chk_pulses("t1_idle_pulses", 4'b0000);

    // 2. backpressure on client 1
    gnt_1 = 1; vld_1 = 1;
    tick();
    beats = 0;
    for (int c = 0; c < 7; c++) begin
      out_rdy = (c % 2 == 0);
      data_1  = 8'hB0 + 8'(beats);
      #1;
      chk("t2_rdy1", rdy_1, out_rdy);
      chk("t2_rdy0", rdy_0, 0);
      chk("t2_data", out_data, 8'hB0 + beats);
      chk_pulses("t2_nopulse", 4'b0000);
      if (out_rdy) beats++;
      tick();
    end
    gnt_1 = 0; vld_1 = 0; out_rdy = 0;
    #1;
    chk_pulses("t2_done", 4'b0100);
    tick();
    chk("t2_idle_busy", busy, 0);
    chk_pulses("t2_idle_pulses", 4'b0000);

    // 3. timeout on client 0
    gnt_0 = 1; vld_0 = 1; out_rdy = 0;
    tick();
    for (int c = 0; c < 15; c++) begin
      #1;
      chk("t3_busy", busy, 1);
      chk("t3_rdy0", rdy_0, 0);
      chk_pulses("t3_nopulse", 4'b0000);
      tick();
    end
    gnt_0 = 0; vld_0 = 0;
    #1;
    chk_pulses("t3_abort", 4'b0010);
    tick();
    chk("t3_idle_busy", busy, 0);
    chk_pulses("t3_idle_pulses", 4'b0000);

    // 4a. grant drop after two beats
    gnt_1 = 1; vld_1 = 1; out_rdy = 1;
    tick();
    tick(); tick();
    gnt_1 = 0;
    #1;
    chk_pulses("t4a_nopulse", 4'b0000);
    tick();
    vld_1 = 0;
    #1;
    chk_pulses("t4a_abort", 4'b0001);
    tick();
    chk("t4a_idle_busy", busy, 0);

    // 4b. grant drop coinciding with final beat counts as done
    gnt_1 = 1; vld_1 = 1; out_rdy = 1;
    tick();
    tick(); tick(); tick();
    gnt_1 = 0;
    #1;
    chk("t4b_last_rdy", rdy_1, 1);
    tick();
    vld_1 = 0;
    #1;
    chk_pulses("t4b_done", 4'b0100);
    tick();
    chk("t4b_idle_busy", busy, 0);

    // 5. both grants in IDLE: client 0 wins
    gnt_0 = 1; gnt_1 = 1; vld_0 = 1; vld_1 = 1; out_rdy = 1; data_1 = 8'hFF;
    tick();
    for (int i = 0; i < 4; i++) begin
      data_0 = 8'hC0 + 8'(i);
      #1;
      chk("t5_rdy1", rdy_1, 0);
      chk("t5_data", out_data, 8'hC0 + i);
      tick();
    end
    gnt_0 = 0; gnt_1 = 0; vld_0 = 0; vld_1 = 0;
    #1;
    chk_pulses("t5_done", 4'b1000);
    tick();
    chk("t5_idle_busy", busy, 0);

    // 6. reset mid-burst, then a fresh full burst
    gnt_0 = 1; vld_0 = 1; out_rdy = 1;
    tick();
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; gnt_0 = 0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_out_vld", out_vld, 0);
    chk_pulses("t6_nopulse", 4'b0000);
    tick();
    chk_pulses("t6_nopulse2", 4'b0000);
    gnt_0 = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      data_0 = 8'hD0 + 8'(i);
      #1;
      chk("t6_data", out_data, 8'hD0 + i);
      chk_pulses("t6_burst_nopulse", 4'b0000);
      tick();
    end
    gnt_0 = 0; vld_0 = 0;
    #1;
    chk_pulses("t6_done", 4'b1000);
    tick();
    chk("t6_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grant_bus_ctrl.md
Name: grant_bus_ctrl

Overview:
- Sits directly downstream of the two-requester arbiter and consumes its gnt_0/gnt_1 outputs.
- Gives the granted client exclusive ownership of a shared target bus for one fixed-length burst.
- Forwards that client's data beats over a valid/ready handshake, then pulses done or abort back to the client so it can drop its request.

Parameters:
- DATA_W, 8, width of client and target data.
- BURST_LEN, 4, beats per burst; legal range 1..255.
- TIMEOUT, 15, idle cycles without an accepted beat before the burst is aborted; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- gnt_0  in  1  grant to client 0, from arbiter
- gnt_1  in  1  grant to client 1, from arbiter
- data_0  in  DATA_W  client 0 beat data
- vld_0  in  1  client 0 beat valid
- rdy_0  out  1  client 0 beat accepted this cycle
- data_1  in  DATA_W  client 1 beat data
- vld_1  in  1  client 1 beat valid
- rdy_1  out  1  client 1 beat accepted this cycle
- out_data  out  DATA_W  target bus data
- out_vld  out  1  target bus valid
- out_rdy  in  1  target ready
- done_0  out  1  one-cycle pulse: client 0 burst completed
- done_1  out  1  one-cycle pulse: client 1 burst completed
- abort_0  out  1  one-cycle pulse: client 0 burst aborted
- abort_1  out  1  one-cycle pulse: client 1 burst aborted
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE; beat_cnt = 0; idle_cnt = 0; all done/abort = 0.
  - Forwarding outputs in IDLE: out_vld = 0, out_data = 0, rdy_0 = rdy_1 = 0.
  - busy = 0.
- Reset mid-burst: return to IDLE on the next edge. No done or abort pulse is emitted.
- States: IDLE, OWN0, OWN1, FIN. State, the counters and the done/abort pulses are registered; forwarding is combinational from state.
- IDLE:
  - gnt_0 = 1 -> OWN0.
  - Else gnt_1 = 1 -> OWN1.
  - Both high: client 0 wins. This cannot come from the arbiter, but the behaviour is defined.
  - Counters are cleared on entry to OWN0/OWN1.
- OWN0 forwarding: out_data = data_0, out_vld = vld_0, rdy_0 = out_rdy & vld_0, rdy_1 = 0. OWN1 is the mirror image.
- Accepted beat = out_vld & out_rdy. On an accepted beat:
  - beat_cnt increments and idle_cnt clears.
  - If beat_cnt == BURST_LEN-1 -> FIN with a done flag.
- Cycle without an accepted beat:
  - idle_cnt increments.
  - If idle_cnt == TIMEOUT-1 -> FIN with an abort flag.
- Grant drop: if the owner's grant is 0 in OWNx -> FIN with an abort flag.
- Priority when events coincide in one cycle: last-beat accept beats grant drop beats timeout. A final beat accepted in the same cycle the grant drops counts as done.
- FIN (exactly one cycle):
  - done_x or abort_x is high for the owning client.
  - Forwarding outputs are idle.
  - Next state IDLE. The earliest new ownership is the cycle after FIN.
- Latency:
  - Grant high at edge N -> OWNx visible after edge N.
  - Burst of BURST_LEN beats with out_rdy and vld held high = BURST_LEN cycles in OWNx + 1 FIN cycle.
- Counters are 8 bits wide and never wrap, because every terminal condition exits the state first.
- The non-owner's vld and data are ignored. The non-owner's rdy is 0.
- busy = 1 in OWN0, OWN1 and FIN.

Test Plan:
1. Basic burst: rst 2 cycles; gnt_0 = 1, vld_0 = 1, out_rdy = 1, data_0 = 0xA0..0xA3 -> out_data sequence A0, A1, A2, A3 on 4 consecutive cycles; done_0 = 1 on the 5th cycle; busy low after.
2. Backpressure: client 1 granted; out_rdy toggles 1, 0, 1, 0 -> 4 beats over 7 cycles; rdy_1 mirrors out_rdy; done_1 pulses once; no abort.
3. Timeout: gnt_0 = 1, vld_0 = 1, out_rdy = 0 for 15 cycles -> abort_0 pulses in the cycle after the 15th stall; no done_0; IDLE next.
4. Grant drop: gnt_1 falls after 2 of 4 beats -> abort_1 one cycle later. Second variant: gnt_1 falls with the final beat accepted in the same cycle -> done_1, not abort_1.
5. Contention: gnt_0 = gnt_1 = 1 in IDLE -> OWN0; rdy_1 stays 0 throughout; the client 0 burst completes normally.
6. Reset mid-burst: rst after beat 2 -> IDLE next edge; out_vld = 0; no done/abort pulses; a fresh grant afterwards runs a full 4-beat burst.
